// File: rtl/mem_sweep_checker_if.sv
// Memory-side bus of mem_sweep_checker: read address, write address, write
// data and the 1-cycle registered read data of the test memory.
interface mem_sweep_checker_if #(
    parameter int WID_MEM = 15
);
    logic [31:0]        raddr;
    logic [31:0]        waddr;
    logic [WID_MEM-1:0] din;
    logic [WID_MEM-1:0] dout;

    modport master (output raddr, output waddr, output din, input dout);
    modport slave  (input raddr, input waddr, input din, output dout);
endinterface

// File: rtl/mem_sweep_checker.sv
// Address/data driver and readback checker for the single-port-style test
// memory (1-cycle registered read, unconditional write every clock).
// Either verifies the current contents against pat(a) = a ^ SEED, or fills
// the pattern first and then verifies it. Outside FILL every word read is
// written straight back, so the unconditional write never corrupts contents.
// Optional build macro MEM_SWEEP_INJECT_EN adds input inj: when latched at
// start, the expected value of address 5 has bit 0 inverted (checker self-test).
module mem_sweep_checker #(
    parameter int WID_MEM    = 15,
    parameter int DEPTH_MEM  = 1024,
    parameter int SEED       = 0,
    parameter int PARK_ADDR  = DEPTH_MEM - 1,
    parameter int SWEEP_LAST = DEPTH_MEM - 2,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
`ifdef MEM_SWEEP_INJECT_EN
    input  logic                       inj,
`endif
    mem_sweep_checker_if.master        mem,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CNT_W-1:0]           err_count,
    output logic [31:0]                first_err_addr
);
    localparam int                 AW     = $clog2(DEPTH_MEM);
    localparam logic [AW-1:0]      PARK_A = AW'(PARK_ADDR);
    localparam logic [AW-1:0]      LAST_A = AW'(SWEEP_LAST);
    localparam logic [WID_MEM-1:0] SEED_W = WID_MEM'(SEED);

    typedef enum logic [1:0] {IDLE, FILL, SWEEP, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [AW-1:0]      k, k_nxt;          // fill / sweep address counter
    logic [AW-1:0]      raddr_c;           // read address chosen by the FSM
    logic [AW-1:0]      raddr_prev;        // address whose data is on dout now
    logic               rst_d;             // first cycle after reset
    logic               cmp_vld;           // dout carries a swept word
    logic               mismatch;
    logic [WID_MEM-1:0] expected;
    logic               done_q;
    logic [CNT_W-1:0]   err_q;
    logic [31:0]        first_q;
`ifdef MEM_SWEEP_INJECT_EN
    logic               inj_q;
`endif

    function automatic logic [WID_MEM-1:0] pat(input logic [AW-1:0] a);
        return WID_MEM'(a) ^ SEED_W;
    endfunction

    // State and address counter register; reset aborts any run at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Next state, counter advance and read address for the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        k_nxt     = k;
        raddr_c   = PARK_A;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = mode ? FILL : SWEEP;
                    k_nxt     = '0;
                end
            end
            FILL: begin
                if (k == LAST_A) begin
                    state_nxt = SWEEP;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            SWEEP: begin
                raddr_c = k;
                if (k == LAST_A) state_nxt = DRAIN;
                else             k_nxt     = k + 1'b1;
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Expected word for the address whose data is arriving on dout.
    always_comb begin
        expected = pat(raddr_prev);
`ifdef MEM_SWEEP_INJECT_EN
        if (inj_q && raddr_prev == AW'(5)) expected[0] = ~expected[0];
`endif
    end

    assign mismatch = (mem.dout != expected);

    // Read pipeline tracking, run results and the sticky done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_d      <= 1'b1;
            raddr_prev <= PARK_A;
            cmp_vld    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            first_q    <= '0;
`ifdef MEM_SWEEP_INJECT_EN
            inj_q      <= 1'b0;
`endif
        end else begin
            rst_d      <= 1'b0;
            raddr_prev <= raddr_c;
            cmp_vld    <= (state == SWEEP);
            if (state == IDLE && start) begin
                done_q  <= 1'b0;
                err_q   <= '0;
                first_q <= '0;
`ifdef MEM_SWEEP_INJECT_EN
                inj_q   <= inj;
`endif
            end
            // cmp_vld is never set in IDLE, so this cannot collide with a start.
            if (cmp_vld && mismatch) begin
                if (err_q != '1) err_q   <= err_q + 1'b1;
                if (err_q == '0) first_q <= 32'(raddr_prev);
            end
            if (state == DRAIN) done_q <= 1'b1;
        end
    end

    // Memory bus: FILL drives the pattern, otherwise write back the word just read.
    always_comb begin
        mem.raddr = 32'(reset ? PARK_A : raddr_c);
        mem.waddr = 32'(raddr_prev);
        mem.din   = mem.dout;
        if (reset || rst_d) begin
            mem.waddr = 32'(PARK_A);
            mem.din   = '0;
        end else if (state == FILL) begin
            mem.waddr = 32'(k);
            mem.din   = pat(k);
        end
    end

    // Status outputs read as reset values while reset is asserted.
    assign busy           = ~reset & (state != IDLE);
    assign done           = ~reset & done_q;
    assign err_count      = reset ? '0 : err_q;
    assign first_err_addr = reset ? '0 : first_q;
    assign pass           = done & (err_q == '0);

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Self-checking bench for mem_sweep_checker: behavioural memory, directed
// scenarios with literal expectations, randomized images and a per-cycle bus
// monitor derived from run-offset arithmetic.
module tb_mem_sweep_checker;
    localparam int W    = 15;
    localparam int D    = 1024;
    localparam int AW   = $clog2(D);
    localparam int CW   = 4;
    localparam int SEED = 0;
    localparam int PARK = D - 1;
    localparam int LAST = D - 2;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, mode, inj;
    logic          busy, done, pass;
    logic [CW-1:0] err_count;
    logic [31:0]   first_err_addr;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    mem_sweep_checker_if #(.WID_MEM(W)) mem_if ();

    mem_sweep_checker #(
        .WID_MEM(W), .DEPTH_MEM(D), .SEED(SEED), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
`ifdef MEM_SWEEP_INJECT_EN
        .inj(inj),
`endif
        .mem(mem_if),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Test memory: registered read, unconditional write, bench-side bulk load.
    logic [W-1:0] ram [D];
    logic [W-1:0] img [D];
    logic [W-1:0] pre [D];
    logic         load_en;
    always @(posedge clk) begin
        mem_if.dout <= ram[mem_if.raddr[AW-1:0]];
        if (load_en) ram <= img;
        else         ram[mem_if.waddr[AW-1:0]] <= mem_if.din;
    end

    function automatic logic [W-1:0] pat(input int a);
        return W'(a ^ SEED);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle bus monitor: expectations from the run offset n since start.
    bit          mon_on = 1'b0;
    bit          mon_mode;
    int          mon_base;
    logic [31:0] mon_prev;
    always @(negedge clk) begin : monitor
        int          n, fl, lat, j;
        logic [31:0] er;
        bit          in_fill;
        if (mon_on && !reset) begin
            n = cyc - mon_base;
            if (n >= 1) begin
                fl      = mon_mode ? LAST + 1 : 0;
                lat     = fl + LAST + 3;
                in_fill = (n <= fl);
                j       = n - 1 - fl;
                er      = (!in_fill && j >= 0 && j <= LAST) ? 32'(j) : 32'(PARK);
                check("mon_raddr", 64'(mem_if.raddr), 64'(er));
                if (in_fill) begin
                    check("mon_fill_waddr", 64'(mem_if.waddr), 64'(n - 1));
                    check("mon_fill_din", 64'(mem_if.din), 64'(pat(n - 1)));
                end else begin
                    check("mon_wb_waddr", 64'(mem_if.waddr), 64'(mon_prev));
                    check("mon_wb_din", 64'(mem_if.din), 64'(mem_if.dout));
                end
                check("mon_busy", 64'(busy), 64'(n < lat));
                check("mon_done", 64'(done), 64'(n >= lat));
                mon_prev = er;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_raddr"}, 64'(mem_if.raddr), 64'(PARK));
        check({tag, "_waddr"}, 64'(mem_if.waddr), 64'(PARK));
        check({tag, "_din"}, 64'(mem_if.din), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'd0);
        check({tag, "_first"}, 64'(first_err_addr), 64'd0);
    endtask

    // Copy img into memory; the park word is scratch and keeps its live value
    // because its in-flight writeback would restore it anyway.
    task automatic load();
        @(posedge clk); #1;
        img[PARK] = ram[PARK];
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic img_clean();
        for (int a = 0; a < D; a++) img[a] = pat(a);
    endtask

    // One complete run against the model; extra_at >= 1 pulses start again
    // at that run offset (must be ignored).
    task automatic run(input bit m, input bit ij, input int extra_at, output int took);
        int           cnt, first, lat, diff;
        logic [W-1:0] v, e;
        bit           ij_eff;
`ifdef MEM_SWEEP_INJECT_EN
        ij_eff = ij;
`else
        ij_eff = 1'b0;
`endif
        pre = ram;
        cnt = 0;
        first = 0;
        for (int a = 0; a <= LAST; a++) begin
            v = m ? pat(a) : pre[a];
            e = pat(a);
            if (ij_eff && a == 5) e[0] = ~e[0];
            if (v != e) begin
                if (cnt == 0) first = a;
                cnt++;
            end
        end
        lat = m ? 2 * (LAST + 1) + 2 : LAST + 3;

        @(posedge clk); #1;
        mon_base = cyc;
        mon_mode = m;
        mon_prev = 32'(PARK);
        mon_on   = 1'b1;
        mode  = m;
        inj   = ij;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        took  = 1;
        while (!done && took < lat + 50) begin
            start = (took == extra_at);
            @(posedge clk); #1;
            took++;
        end
        start = 1'b0;
        check("run_latency", 64'(took), 64'(lat));
        check("run_err", 64'(err_count), 64'(cnt > SAT ? SAT : cnt));
        check("run_first", 64'(first_err_addr), 64'(first));
        check("run_pass", 64'(pass), 64'(cnt == 0));
        check("run_busy_end", 64'(busy), 64'd0);

        diff = 0;
        for (int a = 0; a <= LAST; a++) if (ram[a] != (m ? pat(a) : pre[a])) diff++;
        if (ram[PARK] != pre[PARK]) diff++;
        check("run_mem_words_wrong", 64'(diff), 64'd0);
        @(negedge clk);
        mon_on = 1'b0;
    endtask

    initial begin
        int           took, w, nerr, a;
        bit           m, ij;
        logic [W-1:0] park_before;

        reset = 1'b1; start = 1'b0; mode = 1'b0; inj = 1'b0; load_en = 1'b0;

        // Reset held 3 cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_release");

        // FILL_VERIFY over arbitrary contents.
        for (int i = 0; i < D; i++) img[i] = W'($urandom);
        load();
        park_before = ram[PARK];
        run(1'b1, 1'b0, -1, took);
        check("fv_latency_lit", 64'(took), 64'd2048);
        check("fv_err_lit", 64'(err_count), 64'd0);
        check("fv_pass_lit", 64'(pass), 64'd1);
        check("fv_word_1022", 64'(ram[1022]), 64'd1022);
        check("fv_word_park", 64'(ram[PARK]), 64'(park_before));

        // VERIFY on a clean preload.
        img_clean();
        load();
        run(1'b0, 1'b0, -1, took);
        check("v_latency_lit", 64'(took), 64'd1025);
        check("v_pass_lit", 64'(pass), 64'd1);

        // Two corrupted words.
        img_clean();
        img[10]  = 15'h7FFF;
        img[700] = 15'h7FFF;
        load();
        run(1'b0, 1'b0, -1, took);
        check("bad2_err_lit", 64'(err_count), 64'd2);
        check("bad2_first_lit", 64'(first_err_addr), 64'd10);
        check("bad2_pass_lit", 64'(pass), 64'd0);

        // Abort mid-sweep with reset (start held alongside: reset wins).
        @(posedge clk); #1;
        mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (mem_if.raddr != 32'd300 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        check("abort_reach_300", 64'(mem_if.raddr), 64'd300);
        check("abort_err_before", 64'(err_count), 64'd1);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        check_reset_vals("abort_in_rst");
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check_reset_vals("abort_after");

        // Fresh run with a stray start pulse mid-run.
        img_clean();
        load();
        run(1'b0, 1'b0, 500, took);
        check("restart_latency_lit", 64'(took), 64'd1025);
        check("restart_pass_lit", 64'(pass), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("restart_still_done", 64'(done), 64'd1);
        check("restart_not_busy", 64'(busy), 64'd0);

        // All-zero memory: counter saturates.
        for (int i = 0; i < D; i++) img[i] = '0;
        load();
        run(1'b0, 1'b0, -1, took);
        check("zero_err_sat_lit", 64'(err_count), 64'd15);
        check("zero_first_lit", 64'(first_err_addr), 64'd1);

`ifdef MEM_SWEEP_INJECT_EN
        img_clean();
        load();
        run(1'b0, 1'b1, -1, took);
        check("inj_err_lit", 64'(err_count), 64'd1);
        check("inj_first_lit", 64'(first_err_addr), 64'd5);
`endif

        // Randomized images and modes against the model.
        for (int it = 0; it < 6; it++) begin
            img_clean();
            nerr = (it == 2) ? D : int'($urandom_range(0, 20));
            for (int e = 0; e < nerr; e++) begin
                a = (it == 2) ? e : int'($urandom_range(0, LAST));
                img[a] = W'($urandom);
            end
            load();
            m  = 1'($urandom_range(0, 1));
            ij = 1'($urandom_range(0, 1));
            run(m, ij, (it == 4) ? 37 : -1, took);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
